// File: rtl/utf8_pkg.sv
// Shared definitions for the byte-serial UTF-8 codec.
//   state_t       : controller states (IDLE, COLLECT, EMIT)
//   *_CP, SURR_*  : code-point limits used by both directions
//   UIO_*         : bit positions inside uio_in / uio_out
//   cont_ok()     : legality of a decode continuation byte
package utf8_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam logic [20:0] REPLACEMENT_CP = 21'h00FFFD;
  localparam logic [20:0] MAX_CP         = 21'h10FFFF;
  localparam logic [20:0] SURR_LO        = 21'h00D800;
  localparam logic [20:0] SURR_HI        = 21'h00DFFF;

  // uio_in strobes
  localparam int UIO_WR    = 0;
  localparam int UIO_RD    = 1;
  localparam int UIO_MODE  = 2;
  localparam int UIO_CLR   = 3;
  // uio_out status flags
  localparam int UIO_READY = 4;
  localparam int UIO_VALID = 5;
  localparam int UIO_ERROR = 6;
  localparam int UIO_LAST  = 7;

  // A continuation byte must be 10xxxxxx. The byte right after certain
  // lead bytes has a narrower range, which rejects overlong forms,
  // surrogates and values above U+10FFFF without decoding them first.
  function automatic logic cont_ok(input logic [7:0] lead,
                                   input logic [7:0] b,
                                   input logic       second);
    logic ok;
    ok = (b[7:6] == 2'b10);
    if (second) begin
      case (lead)
        8'hE0:   ok = ok && (b >= 8'hA0);
        8'hED:   ok = ok && (b <= 8'h9F);
        8'hF0:   ok = ok && (b >= 8'h90);
        8'hF4:   ok = ok && (b <= 8'h8F);
        default: ok = ok;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/utf8_encode.sv
// Combinational UTF-8 encoder.
//   cp    in  21  code point
//   bytes out 32  encoded bytes, first byte in [31:24], unused low bytes 0
//   len   out  3  number of valid bytes (1..4)
//   err   out  1  cp was a surrogate or above U+10FFFF; U+FFFD was encoded instead
module utf8_encode
  import utf8_pkg::*;
(
  input  logic [20:0] cp,
  output logic [31:0] bytes,
  output logic [2:0]  len,
  output logic        err
);

  logic [20:0] c;

  assign err = (cp > MAX_CP) || ((cp >= SURR_LO) && (cp <= SURR_HI));
  assign c   = err ? REPLACEMENT_CP : cp;

  always_comb begin
    bytes = 32'h0;
    len   = 3'd1;
    if (c < 21'h80) begin
      bytes = {c[7:0], 24'h0};
      len   = 3'd1;
    end else if (c < 21'h800) begin
      bytes = {3'b110, c[10:6], 2'b10, c[5:0], 16'h0};
      len   = 3'd2;
    end else if (c < 21'h10000) begin
      bytes = {4'b1110, c[15:12], 2'b10, c[11:6], 2'b10, c[5:0], 8'h0};
      len   = 3'd3;
    end else begin
      bytes = {5'b11110, c[20:18], 2'b10, c[17:12], 2'b10, c[11:6], 2'b10, c[5:0]};
      len   = 3'd4;
    end
  end

endmodule

// File: rtl/hardware_utf8_core.sv
// Byte-serial UTF-8 codec core.
//   clk, rst : clock, synchronous active-high reset
//   ena      : design selected; when low every strobe (including CLR) is ignored
//   ui_in    : input data byte
//   uio_in   : [0] WR, [1] RD, [2] MODE (0 decode, 1 encode), [3] CLR
//   uo_out   : current output byte, 0x00 unless VALID
//   uio_out  : [4] READY, [5] VALID, [6] ERROR, [7] LAST
//   uio_oe   : constant 8'hF0
// Decode: UTF-8 bytes in, code point out as 4 bytes big-endian.
// Encode: 4-byte big-endian code point in, 1..4 UTF-8 bytes out.
module hardware_utf8_core
  import utf8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic wr, rd, clr, mode_in;
  assign wr      = ena & uio_in[UIO_WR];
  assign rd      = ena & uio_in[UIO_RD];
  assign clr     = ena & uio_in[UIO_CLR];
  assign mode_in = uio_in[UIO_MODE];

  logic unused_uio;
  assign unused_uio = ^uio_in[7:4];

  state_t      state_reg, state_next;
  logic        mode_reg, mode_next;
  logic        err_reg, err_next;
  logic [20:0] cp_reg, cp_next;
  logic        ovf_reg, ovf_next;      // encode: a bit above cp[20] was set
  logic [2:0]  in_cnt_reg, in_cnt_next;
  logic [2:0]  need_reg, need_next;    // decode: total sequence length
  logic [7:0]  lead_reg, lead_next;
  logic [31:0] out_bytes_reg, out_bytes_next;
  logic [1:0]  out_idx_reg, out_idx_next;
  logic [1:0]  last_idx_reg, last_idx_next;

  // Encoder sees the accumulator with the final byte shifted in; any
  // bit lost off the top forces an out-of-range value so it flags error.
  logic [20:0] enc_cp;
  logic [31:0] enc_bytes;
  logic [2:0]  enc_len;
  logic        enc_err;

  assign enc_cp = (ovf_reg || (|cp_reg[20:13])) ? 21'h1FFFFF : {cp_reg[12:0], ui_in};

  utf8_encode u_encode (
    .cp    (enc_cp),
    .bytes (enc_bytes),
    .len   (enc_len),
    .err   (enc_err)
  );

  logic [20:0] dec_cp;
  assign dec_cp = {cp_reg[14:0], ui_in[5:0]};

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    err_next       = err_reg;
    cp_next        = cp_reg;
    ovf_next       = ovf_reg;
    in_cnt_next    = in_cnt_reg;
    need_next      = need_reg;
    lead_next      = lead_reg;
    out_bytes_next = out_bytes_reg;
    out_idx_next   = out_idx_reg;
    last_idx_next  = last_idx_reg;

    case (state_reg)
      IDLE, COLLECT: begin
        if (wr) begin
          if (state_reg == IDLE) mode_next = mode_in;
          out_idx_next = 2'd0;
          if ((state_reg == IDLE) ? mode_in : mode_reg) begin
            // encode: shift bytes in MSB first
            if (state_reg == IDLE) begin
              cp_next     = {13'h0, ui_in};
              ovf_next    = 1'b0;
              in_cnt_next = 3'd1;
              state_next  = COLLECT;
            end else if (in_cnt_reg == 3'd3) begin
              out_bytes_next = enc_bytes;
              last_idx_next  = 2'(enc_len - 3'd1);
              err_next       = enc_err;
              state_next     = EMIT;
            end else begin
              ovf_next    = ovf_reg | (|cp_reg[20:13]);
              cp_next     = {cp_reg[12:0], ui_in};
              in_cnt_next = in_cnt_reg + 3'd1;
            end
          end else begin
            // decode: results are always 4 bytes long
            last_idx_next = 2'd3;
            if (state_reg == IDLE) begin
              lead_next   = ui_in;
              in_cnt_next = 3'd1;
              if (ui_in < 8'h80) begin
                out_bytes_next = {24'h0, ui_in};
                err_next       = 1'b0;
                state_next     = EMIT;
              end else if (ui_in >= 8'hC2 && ui_in <= 8'hDF) begin
                cp_next    = {16'h0, ui_in[4:0]};
                need_next  = 3'd2;
                state_next = COLLECT;
              end else if (ui_in >= 8'hE0 && ui_in <= 8'hEF) begin
                cp_next    = {17'h0, ui_in[3:0]};
                need_next  = 3'd3;
                state_next = COLLECT;
              end else if (ui_in >= 8'hF0 && ui_in <= 8'hF4) begin
                cp_next    = {18'h0, ui_in[2:0]};
                need_next  = 3'd4;
                state_next = COLLECT;
              end else begin
                out_bytes_next = {11'h0, REPLACEMENT_CP};
                err_next       = 1'b1;
                state_next     = EMIT;
              end
            end else if (!cont_ok(lead_reg, ui_in, in_cnt_reg == 3'd1)) begin
              // bad byte is swallowed; no resync replay
              out_bytes_next = {11'h0, REPLACEMENT_CP};
              err_next       = 1'b1;
              state_next     = EMIT;
            end else begin
              cp_next     = dec_cp;
              in_cnt_next = in_cnt_reg + 3'd1;
              if (in_cnt_reg + 3'd1 == need_reg) begin
                out_bytes_next = {11'h0, dec_cp};
                err_next       = 1'b0;
                state_next     = EMIT;
              end
            end
          end
        end
      end
      EMIT: begin
        if (rd) begin
          if (out_idx_reg == last_idx_reg) begin
            state_next  = IDLE;
            err_next    = 1'b0;
            in_cnt_next = 3'd0;
          end else begin
            out_idx_next = out_idx_reg + 2'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_reg     <= IDLE;
      mode_reg      <= 1'b0;
      err_reg       <= 1'b0;
      cp_reg        <= 21'h0;
      ovf_reg       <= 1'b0;
      in_cnt_reg    <= 3'd0;
      need_reg      <= 3'd0;
      lead_reg      <= 8'h0;
      out_bytes_reg <= 32'h0;
      out_idx_reg   <= 2'd0;
      last_idx_reg  <= 2'd0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      err_reg       <= err_next;
      cp_reg        <= cp_next;
      ovf_reg       <= ovf_next;
      in_cnt_reg    <= in_cnt_next;
      need_reg      <= need_next;
      lead_reg      <= lead_next;
      out_bytes_reg <= out_bytes_next;
      out_idx_reg   <= out_idx_next;
      last_idx_reg  <= last_idx_next;
    end
  end

  // Output byte lanes, lane 0 = first byte sent.
  logic [7:0] out_lane [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign out_lane[gi] = out_bytes_reg[31 - 8*gi -: 8];
  end

  logic valid;
  assign valid   = (state_reg == EMIT);
  assign uo_out  = valid ? out_lane[out_idx_reg] : 8'h00;
  assign uio_out = {valid && (out_idx_reg == last_idx_reg), err_reg, valid, !valid, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_hardware_utf8_core.sv
module tb_hardware_utf8_core;

  logic       clk = 1'b0;
  logic       rst, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  hardware_utf8_core dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    string       name;
    logic        mode;
    int          nin;
    logic [31:0] din;   // input bytes, first in [31:24]
    int          nexp;
    logic [31:0] dexp;  // expected bytes, first in [31:24]
    logic        err;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic       err;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[18];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input logic mode);
    ui_in  = b;
    uio_in = {5'b0, mode, 2'b01};
    cyc();
    uio_in = 8'h00;
  endtask

  task automatic rd();
    uio_in = 8'h02;
    cyc();
    uio_in = 8'h00;
  endtask

  task automatic push_exp(input logic [31:0] d, input int n, input logic err);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.b    = d[31 - 8*j -: 8];
      e.last = (j == n - 1);
      e.err  = err;
      sbq.push_back(e);
    end
  endtask

  // Pops the scoreboard one byte per RD; bounded by the queue length.
  task automatic drain(input string name);
    exp_t e;
    int   guard;
    chk({name, " valid"}, {31'h0, uio_out[5]}, 32'h1);
    guard = 0;
    while (sbq.size() > 0 && guard < 8) begin
      e = sbq.pop_front();
      chk({name, " byte"}, {22'h0, uio_out[7], uio_out[6], uo_out},
          {22'h0, e.last, e.err, e.b});
      rd();
      guard++;
    end
    chk({name, " idle"}, {24'h0, uio_out}, 32'h10);
    $display("txn %s done", name);
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.nin; i++)
      wr(v.din[31 - 8*i -: 8], (i == 0) ? v.mode : ~v.mode);  // later MODE must be ignored
    push_exp(v.dexp, v.nexp, v.err);
    drain(v.name);
  endtask

  function automatic vec_t mk(input string name, input logic mode, input int nin,
                              input logic [31:0] din, input int nexp,
                              input logic [31:0] dexp, input logic err);
    vec_t v;
    v.name = name; v.mode = mode; v.nin = nin; v.din = din;
    v.nexp = nexp; v.dexp = dexp; v.err = err;
    return v;
  endfunction

  task automatic chk_reset(input string name);
    chk({name, " uo_out"},  {24'h0, uo_out},  32'h00);
    chk({name, " uio_out"}, {24'h0, uio_out}, 32'h10);
    chk({name, " uio_oe"},  {24'h0, uio_oe},  32'hF0);
  endtask

  initial begin
    vecs[0]  = mk("dec_euro",     1'b0, 3, 32'hE282AC00, 4, 32'h000020AC, 1'b0);
    vecs[1]  = mk("dec_C0",       1'b0, 1, 32'hC0000000, 4, 32'h0000FFFD, 1'b1);
    vecs[2]  = mk("dec_E2_41",    1'b0, 2, 32'hE2410000, 4, 32'h0000FFFD, 1'b1);
    vecs[3]  = mk("dec_ED_A0",    1'b0, 2, 32'hEDA00000, 4, 32'h0000FFFD, 1'b1);
    vecs[4]  = mk("enc_41",       1'b1, 4, 32'h00000041, 1, 32'h41000000, 1'b0);
    vecs[5]  = mk("enc_1F600",    1'b1, 4, 32'h0001F600, 4, 32'hF09F9880, 1'b0);
    vecs[6]  = mk("enc_7FF",      1'b1, 4, 32'h000007FF, 2, 32'hDFBF0000, 1'b0);
    vecs[7]  = mk("enc_D800",     1'b1, 4, 32'h0000D800, 3, 32'hEFBFBD00, 1'b1);
    vecs[8]  = mk("enc_110000",   1'b1, 4, 32'h00110000, 3, 32'hEFBFBD00, 1'b1);
    vecs[9]  = mk("dec_1F600",    1'b0, 4, 32'hF09F9880, 4, 32'h0001F600, 1'b0);
    vecs[10] = mk("dec_ascii",    1'b0, 1, 32'h24000000, 4, 32'h00000024, 1'b0);
    vecs[11] = mk("dec_F4_90",    1'b0, 2, 32'hF4900000, 4, 32'h0000FFFD, 1'b1);
    vecs[12] = mk("dec_E0_80",    1'b0, 2, 32'hE0800000, 4, 32'h0000FFFD, 1'b1);
    vecs[13] = mk("enc_10FFFF",   1'b1, 4, 32'h0010FFFF, 4, 32'hF48FBFBF, 1'b0);
    vecs[14] = mk("enc_01000000", 1'b1, 4, 32'h01000000, 3, 32'hEFBFBD00, 1'b1);
    vecs[15] = mk("enc_80",       1'b1, 4, 32'h00000080, 2, 32'hC2800000, 1'b0);
    vecs[16] = mk("dec_C3_A9",    1'b0, 2, 32'hC3A90000, 4, 32'h000000E9, 1'b0);
    vecs[17] = mk("dec_F5",       1'b0, 1, 32'hF5000000, 4, 32'h0000FFFD, 1'b1);

    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    cyc(); cyc();
    chk_reset("reset_held");
    rst = 1'b0;
    cyc();
    chk_reset("reset_released");

    // reset in the middle of EMIT
    wr(8'hE2, 1'b0); wr(8'h82, 1'b0); wr(8'hAC, 1'b0);
    chk("midemit valid", {31'h0, uio_out[5]}, 32'h1);
    rd();
    chk("midemit byte1", {24'h0, uo_out}, 32'h00);
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk_reset("reset_mid_emit");

    foreach (vecs[i]) run_vec(vecs[i]);

    // ena=0: WR and RD pulses must not touch COLLECT state
    wr(8'hE2, 1'b0);
    ena = 1'b0;
    ui_in = 8'h82; uio_in = 8'h01; cyc();
    uio_in = 8'h0B; cyc();               // WR+RD+CLR while deselected
    uio_in = 8'h00; ena = 1'b1;
    chk("ena0 collect", {24'h0, uio_out}, 32'h10);
    wr(8'h82, 1'b0); wr(8'hAC, 1'b0);
    // ena=0 RD during EMIT holds the byte index
    ena = 1'b0; rd(); ena = 1'b1;
    chk("ena0 emit hold", {24'h0, uo_out}, 32'h00);
    // WR during EMIT is ignored
    wr(8'h55, 1'b1);
    push_exp(32'h000020AC, 4, 1'b0);
    drain("ena0_and_wr_in_emit");

    // WR+RD together in COLLECT: WR acts
    ui_in = 8'hC3; uio_in = 8'h03; cyc(); uio_in = 8'h00;
    wr(8'hA9, 1'b0);
    push_exp(32'h000000E9, 4, 1'b0);
    drain("wr_rd_together");

    // CLR mid-COLLECT: next byte is a lead byte again
    wr(8'hE2, 1'b0);
    uio_in = 8'h08; cyc(); uio_in = 8'h00;
    chk("clr idle", {24'h0, uio_out}, 32'h10);
    wr(8'h41, 1'b0);
    push_exp(32'h00000041, 4, 1'b0);
    drain("clr_mid_collect");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
